// File: rtl/vedic_mul_arbiter.sv
// rtl/vedic_mul_arbiter.sv - credit-based two-requester arbiter sharing one pipelined vedic multiplier
// Define VEDIC_ARB_FIXED_PRIO_EN for fixed priority (req0 over req1); default build is round-robin.
`timescale 1ns/1ps
module vedic_mul_arbiter #(
    parameter int WIDTH      = 24,
    parameter int MUL_LAT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res0_valid,
    input  logic             res0_ready,
    output logic [WIDTH-1:0] res0_c,
    output logic             res1_valid,
    input  logic             res1_ready,
    output logic [WIDTH-1:0] res1_c,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_c,
    output logic             busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [1:0]       w_req_valid;
    logic [1:0]       w_res_ready;
    logic [1:0]       w_has_credit;
    logic [1:0]       w_elig;
    logic [1:0]       w_gnt;
    logic [1:0]       w_wr;
    logic [1:0]       w_res_valid;
    logic [WIDTH-1:0] w_res_c [2];
    logic             w_issue;
    logic             w_id;
    logic [MUL_LAT:0] r_tag_v;
    logic [MUL_LAT:0] r_tag_id;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;

    function automatic logic [PW-1:0] f_wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_res_ready = {res1_ready, res0_ready};
    assign w_elig      = w_req_valid & w_has_credit & {2{rst_n}};

`ifdef VEDIC_ARB_FIXED_PRIO_EN
    assign w_gnt[0] = w_elig[0];
`else
    logic r_last;

    // r_last holds the requester granted most recently; reset to 1 so req0 goes first.
    assign w_gnt[0] = w_elig[0] && (!w_elig[1] || r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_issue) begin
            r_last <= w_id;
        end
    end
`endif
    assign w_gnt[1] = w_elig[1] && !w_gnt[0];
    assign w_issue  = |w_gnt;
    assign w_id     = w_gnt[1];

    // Extra tag stage lines the last entry up with the cycle mul_c carries that product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
        end else begin
            r_tag_v  <= {r_tag_v[MUL_LAT-1:0], w_issue};
            r_tag_id <= {r_tag_id[MUL_LAT-1:0], w_id};
            if (w_issue) begin
                r_mul_a <= w_id ? req1_a : req0_a;
                r_mul_b <= w_id ? req1_b : req0_b;
            end
        end
    end

    assign w_wr = {r_tag_v[MUL_LAT] & r_tag_id[MUL_LAT], r_tag_v[MUL_LAT] & ~r_tag_id[MUL_LAT]};

    for (genvar n = 0; n < 2; n++) begin : g_req
        logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [PW-1:0]    r_wr_ptr;
        logic [PW-1:0]    r_rd_ptr;
        logic [CW-1:0]    r_count;
        logic [CW-1:0]    r_credit;
        logic             w_pop;

        assign w_pop = (r_count != '0) && w_res_ready[n];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_credit <= CW'(FIFO_DEPTH);
            end else begin
                if (w_wr[n]) r_wr_ptr <= f_wrap_inc(r_wr_ptr);
                if (w_pop)   r_rd_ptr <= f_wrap_inc(r_rd_ptr);
                if (w_wr[n] && !w_pop)      r_count <= r_count + CW'(1);
                else if (!w_wr[n] && w_pop) r_count <= r_count - CW'(1);
                if (w_gnt[n] && !w_pop)      r_credit <= r_credit - CW'(1);
                else if (!w_gnt[n] && w_pop) r_credit <= r_credit + CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr[n]) r_mem[r_wr_ptr] <= mul_c;
        end

        assign w_has_credit[n] = (r_credit != '0);
        assign w_res_valid[n]  = (r_count != '0);
        assign w_res_c[n]      = r_mem[r_rd_ptr];
    end

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];
    assign res0_valid = w_res_valid[0];
    assign res1_valid = w_res_valid[1];
    assign res0_c     = w_res_c[0];
    assign res1_c     = w_res_c[1];
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign busy       = (|r_tag_v) || (|w_res_valid);
endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// tb/tb_vedic_mul_arbiter.sv - randomized self-checking bench for vedic_mul_arbiter
`timescale 1ns/1ps
module tb_vedic_mul_arbiter;
    localparam int W     = 24;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res0_valid, res0_ready, res1_valid, res1_ready;
    logic [W-1:0] res0_c, res1_c;
    logic [W-1:0] mul_a, mul_b, mul_c;
    logic         busy;

    logic [W-1:0] hist [LAT];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int           fl_id[$];
    int           fl_t[$];
    logic [W-1:0] fl_d[$];
    int           last_g;
    int           edge_n;
    logic [W-1:0] exp_ma, exp_mb;
    int           n_checks;
    int           n_errors;

    vedic_mul_arbiter #(.WIDTH(W), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_c(res0_c),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_c(res1_c),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier stand-in: no reset, so stale products keep flowing through a reset.
    always @(posedge clk) begin
        hist[0] <= mul_a * mul_b;
        for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
    end
    assign mul_c = hist[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_credit(input int n);
        int c;
        c = DEPTH - ((n == 0) ? q0.size() : q1.size());
        foreach (fl_id[i]) if (fl_id[i] == n) c--;
        return c;
    endfunction

    function automatic int exp_grant();
        bit e0, e1;
        e0 = req0_valid && (model_credit(0) > 0);
        e1 = req1_valid && (model_credit(1) > 0);
`ifdef VEDIC_ARB_FIXED_PRIO_EN
        if (e0) return 0;
        if (e1) return 1;
        return -1;
`else
        if (e0 && e1) return (last_g == 0) ? 1 : 0;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
`endif
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        fl_id.delete();
        fl_t.delete();
        fl_d.delete();
        last_g = 1;
        exp_ma = '0;
        exp_mb = '0;
    endtask

    task automatic model_step();
        int g;
        bit p0, p1;
        logic [2*W-1:0] p;
        g  = exp_grant();
        p0 = (q0.size() != 0) && res0_ready;
        p1 = (q1.size() != 0) && res1_ready;
        edge_n++;
        if (p0) q0.delete(0);
        if (p1) q1.delete(0);
        while (fl_t.size() != 0 && (edge_n - fl_t[0]) == LAT + 1) begin
            if (fl_id[0] == 0) q0.push_back(fl_d[0]);
            else q1.push_back(fl_d[0]);
            fl_id.delete(0);
            fl_t.delete(0);
            fl_d.delete(0);
        end
        if (g >= 0) begin
            if (g == 0) p = {{W{1'b0}}, req0_a} * {{W{1'b0}}, req0_b};
            else        p = {{W{1'b0}}, req1_a} * {{W{1'b0}}, req1_b};
            fl_id.push_back(g);
            fl_t.push_back(edge_n);
            fl_d.push_back(p[W-1:0]);
            exp_ma = (g == 0) ? req0_a : req1_a;
            exp_mb = (g == 0) ? req0_b : req1_b;
            last_g = g;
        end
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        int g;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_req0_ready", req0_ready, 0);
                check("rst_req1_ready", req1_ready, 0);
                check("rst_res0_valid", res0_valid, 0);
                check("rst_res1_valid", res1_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_mul_a", mul_a, 0);
                check("rst_mul_b", mul_b, 0);
            end else begin
                g = exp_grant();
                check("req0_ready", req0_ready, g == 0);
                check("req1_ready", req1_ready, g == 1);
                check("res0_valid", res0_valid, q0.size() != 0);
                check("res1_valid", res1_valid, q1.size() != 0);
                if (q0.size() != 0) check("res0_c", res0_c, q0[0]);
                if (q1.size() != 0) check("res1_c", res1_c, q1[0]);
                check("busy", busy, (fl_id.size() != 0) || (q0.size() != 0) || (q1.size() != 0));
                check("mul_a", mul_a, exp_ma);
                check("mul_b", mul_b, exp_mb);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic step(output bit [3:0] s);
        #1;
        s = {res1_valid, res0_valid, req1_valid && req1_ready, req0_valid && req0_ready};
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req0_valid = 0;
        req1_valid = 0;
        res0_ready = 1;
        res1_ready = 1;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_busy", busy, 0);
    endtask

    initial begin
        bit [3:0] s;
        int n, n1;
        n_checks = 0;
        n_errors = 0;
        rst_n = 0;
        req0_valid = 0; req1_valid = 0; res0_ready = 0; res1_ready = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // single op: 3 * 5
        req0_a = 24'h000003; req0_b = 24'h000005; req0_valid = 1;
        step(s);
        check("t1_ready", s[0], 1);
        req0_valid = 0;
        repeat (4) step(s);
        check("t1_early_valid", res0_valid, 0);
        step(s);
        check("t1_valid", res0_valid, 1);
        check("t1_product", res0_c, 24'h00000F);
        res0_ready = 1;
        step(s);
        res0_ready = 0;
        check("t1_popped", res0_valid, 0);
        check("t1_busy", busy, 0);

        // both requesters streaming
        res0_ready = 1; res1_ready = 1; req0_valid = 1; req1_valid = 1;
        req0_a = W'($urandom); req0_b = W'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
        n1 = 0;
        for (int i = 0; i < 30; i++) begin
            step(s);
            if (i < 8) check("t2_grant", {s[1], s[0]}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i >= 10 && (s[2] ^ s[3])) n1++;
            if (s[0]) begin req0_a = W'($urandom); req0_b = W'($urandom); end
            if (s[1]) begin req1_a = W'($urandom); req1_b = W'($urandom); end
        end
        check("t2_one_per_cycle", n1, 20);
        drain();

        // credit exhaustion on requester 0
        res0_ready = 0; req0_valid = 1; n = 0;
        for (int i = 0; i < 10; i++) begin
            step(s);
            n += int'(s[0]);
            if (s[0]) begin req0_a = W'($urandom); req0_b = W'($urandom); end
        end
        check("t3_issues", n, 4);
        #1 check("t3_stalled_ready", req0_ready, 0);
        res0_ready = 1;
        step(s);
        res0_ready = 0;
        n = int'(s[0]);
        for (int i = 0; i < 10; i++) begin
            step(s);
            n += int'(s[0]);
        end
        check("t3_one_more", n, 1);

        // requester 1 proceeds while requester 0 has no credit
        req1_valid = 1; res1_ready = 1; n = 0; n1 = 0;
        for (int i = 0; i < 20; i++) begin
            step(s);
            n += int'(s[0]);
            n1 += int'(s[1]);
            if (s[1]) begin req1_a = W'($urandom); req1_b = W'($urandom); end
        end
        check("t4_req0_issues", n, 0);
        check("t4_req1_issues", n1, 12);
        drain();

        // reset with three ops in flight
        req0_valid = 1; res0_ready = 0;
        repeat (3) step(s);
        req0_valid = 0;
        step(s);
        rst_n = 0;
        step(s);
        step(s);
        rst_n = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(s);
            n += int'(s[2] | s[3]);
        end
        check("t5_no_results", n, 0);
        check("t5_busy", busy, 0);
        req0_valid = 1; req1_valid = 1;
        step(s);
        check("t5_first_grant", {s[1], s[0]}, 2'b01);
        req1_valid = 0;
        n = int'(s[0]);
        repeat (9) begin
            step(s);
            n += int'(s[0]);
        end
        check("t5_credits", n, 4);
        drain();

`ifdef VEDIC_ARB_FIXED_PRIO_EN
        req0_valid = 1; req1_valid = 1; res0_ready = 0; res1_ready = 0;
        n = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            step(s);
            if (i < 4) n += int'(s[0]);
            else n1 += int'(s[1]);
        end
        check("t6_req0_first", n, 4);
        check("t6_req1_after", n1, 4);
        drain();
`endif

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (!req0_valid) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a = W'($urandom); req0_b = W'($urandom);
            end
            if (!req1_valid) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = W'($urandom); req1_b = W'($urandom);
            end
            res0_ready = 1'($urandom_range(0, 1));
            res1_ready = 1'($urandom_range(0, 1));
            step(s);
            if (s[0]) req0_valid = 0;
            if (s[1]) req1_valid = 0;
        end
        drain();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
